// File: rtl/ex_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline: load-use stall sequencing
// with a captured load bypass, flush/freeze steering, per-operand forwarding selects and event counters.
module ex_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ex_rs1,
  input  logic [4:0]       ex_rs2,
  input  logic             ex_use_rs1,
  input  logic             ex_use_rs2,
  input  logic [4:0]       exmem_wreg,
  input  logic             exmem_regwrite,
  input  logic             exmem_is_load,
  input  logic [4:0]       memwb_wreg,
  input  logic             memwb_regwrite,
  input  logic [31:0]      memwb_data,
  input  logic [31:0]      load_rdata,
  input  logic             mem_busy,
  input  logic             branch_taken,
  output logic             pc_keep,
  output logic             ifid_keep,
  output logic             ifid_nop,
  output logic             idex_keep,
  output logic             idex_nop,
  output logic             ex_keep,
  output logic             ex_nop,
  output logic [1:0]       fwd_ex_pyc,
  output logic [1:0]       fwd_mem_pyc,
  output logic [1:0]       fwd_stall_load_pyc,
  output logic [1:0]       fwd_mem_hazard_pyc,
  output logic [31:0]      fwd_load_data,
  output logic [31:0]      fwd_retire_data,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, LU_STALL, LU_FWD} state_t;

  typedef struct packed {
    logic ex;
    logic ld;
    logic mem;
    logic hz;
  } fwd_t;

  state_t      state;
  logic [4:0]  l_reg;
  logic        l_valid;
  logic [4:0]  retire_reg;
  logic        retire_valid;

  logic        load_use;
  logic        freeze;
  logic        flush;
  logic        capture;
  fwd_t        fwd_rs1;
  fwd_t        fwd_rs2;

  // x0 is hardwired to zero, so it can never be a forwarding source.
  function automatic logic match(input logic use_r, input logic [4:0] rs, input logic [4:0] r);
    return use_r && (r != 5'd0) && (rs == r);
  endfunction

  function automatic fwd_t pick(
    input logic       use_r,
    input logic [4:0] rs,
    input logic       ex_ok,
    input logic [4:0] ex_reg,
    input logic       ld_ok,
    input logic [4:0] ld_reg,
    input logic       mem_ok,
    input logic [4:0] mem_reg,
    input logic       hz_ok,
    input logic [4:0] hz_reg
  );
    fwd_t f;
    f = '0;
    if (ex_ok && match(use_r, rs, ex_reg))        f.ex  = 1'b1;
    else if (ld_ok && match(use_r, rs, ld_reg))   f.ld  = 1'b1;
    else if (mem_ok && match(use_r, rs, mem_reg)) f.mem = 1'b1;
    else if (hz_ok && match(use_r, rs, hz_reg))   f.hz  = 1'b1;
    return f;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign load_use = exmem_regwrite && exmem_is_load &&
                    (match(ex_use_rs1, ex_rs1, exmem_wreg) ||
                     match(ex_use_rs2, ex_rs2, exmem_wreg));
  assign freeze   = mem_busy;
  assign flush    = !mem_busy && branch_taken;
  // A load-use seen while memory is busy parks in LU_STALL and captures on the first ready cycle.
  assign capture  = !mem_busy && !branch_taken &&
                    (((state == RUN) && load_use) || (state == LU_STALL));

  always_comb begin
    fwd_rs1 = pick(ex_use_rs1, ex_rs1,
                   exmem_regwrite && !exmem_is_load, exmem_wreg,
                   (state == LU_FWD) && l_valid, l_reg,
                   memwb_regwrite, memwb_wreg,
                   retire_valid, retire_reg);
    fwd_rs2 = pick(ex_use_rs2, ex_rs2,
                   exmem_regwrite && !exmem_is_load, exmem_wreg,
                   (state == LU_FWD) && l_valid, l_reg,
                   memwb_regwrite, memwb_wreg,
                   retire_valid, retire_reg);
  end

  // NOTE: every output gets a default before the priority chain so no path infers a latch.
  always_comb begin
    pc_keep            = 1'b0;
    ifid_keep          = 1'b0;
    ifid_nop           = 1'b0;
    idex_keep          = 1'b0;
    idex_nop           = 1'b0;
    ex_keep            = 1'b0;
    ex_nop             = 1'b0;
    fwd_ex_pyc         = 2'b00;
    fwd_stall_load_pyc = 2'b00;
    fwd_mem_pyc        = 2'b00;
    fwd_mem_hazard_pyc = 2'b00;
    if (rst) begin
      fwd_ex_pyc         = {fwd_rs1.ex,  fwd_rs2.ex};
      fwd_stall_load_pyc = {fwd_rs1.ld,  fwd_rs2.ld};
      fwd_mem_pyc        = {fwd_rs1.mem, fwd_rs2.mem};
      fwd_mem_hazard_pyc = {fwd_rs1.hz,  fwd_rs2.hz};
      if (freeze) begin
        pc_keep   = 1'b1;
        ifid_keep = 1'b1;
        idex_keep = 1'b1;
        ex_keep   = 1'b1;
      end else if (flush) begin
        ifid_nop  = 1'b1;
        idex_nop  = 1'b1;
        ex_nop    = 1'b1;
      end else if (capture) begin
        pc_keep   = 1'b1;
        ifid_keep = 1'b1;
        idex_keep = 1'b1;
        ex_nop    = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state           <= RUN;
      fwd_load_data   <= '0;
      l_reg           <= '0;
      l_valid         <= 1'b0;
      retire_reg      <= '0;
      retire_valid    <= 1'b0;
      fwd_retire_data <= '0;
      stall_cnt       <= '0;
      flush_cnt       <= '0;
    end else begin
      if (freeze || capture) stall_cnt <= sat_inc(stall_cnt);
      if (flush)             flush_cnt <= sat_inc(flush_cnt);

      if (!freeze) begin
        retire_reg      <= memwb_wreg;
        fwd_retire_data <= memwb_data;
        retire_valid    <= memwb_regwrite && (memwb_wreg != 5'd0);
      end

      if (freeze) begin
        if ((state == RUN) && load_use) state <= LU_STALL;
      end else if (flush) begin
        state   <= RUN;
        l_valid <= 1'b0;
      end else if (capture) begin
        state         <= LU_FWD;
        fwd_load_data <= load_rdata;
        l_reg         <= exmem_wreg;
        l_valid       <= 1'b1;
      end else if (state == LU_FWD) begin
        state   <= RUN;
        l_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: expected values are queued when each step is driven
// and popped against the DUT at the following falling edge.
module tb_ex_hazard_ctrl;

  localparam int CNT_W = 3;
  localparam logic [6:0] CTL_NONE  = 7'b0000000;
  localparam logic [6:0] CTL_LU    = 7'b1101001;
  localparam logic [6:0] CTL_FRZ   = 7'b1101010;
  localparam logic [6:0] CTL_FLUSH = 7'b0010101;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       ex_rs1, ex_rs2, exmem_wreg, memwb_wreg;
  logic             ex_use_rs1, ex_use_rs2, exmem_regwrite, exmem_is_load, memwb_regwrite;
  logic [31:0]      memwb_data, load_rdata;
  logic             mem_busy, branch_taken;
  logic             pc_keep, ifid_keep, ifid_nop, idex_keep, idex_nop, ex_keep, ex_nop;
  logic [1:0]       fwd_ex_pyc, fwd_mem_pyc, fwd_stall_load_pyc, fwd_mem_hazard_pyc;
  logic [31:0]      fwd_load_data, fwd_retire_data;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  ex_hazard_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_use_rs1(ex_use_rs1), .ex_use_rs2(ex_use_rs2),
    .exmem_wreg(exmem_wreg), .exmem_regwrite(exmem_regwrite), .exmem_is_load(exmem_is_load),
    .memwb_wreg(memwb_wreg), .memwb_regwrite(memwb_regwrite), .memwb_data(memwb_data),
    .load_rdata(load_rdata), .mem_busy(mem_busy), .branch_taken(branch_taken),
    .pc_keep(pc_keep), .ifid_keep(ifid_keep), .ifid_nop(ifid_nop),
    .idex_keep(idex_keep), .idex_nop(idex_nop), .ex_keep(ex_keep), .ex_nop(ex_nop),
    .fwd_ex_pyc(fwd_ex_pyc), .fwd_mem_pyc(fwd_mem_pyc),
    .fwd_stall_load_pyc(fwd_stall_load_pyc), .fwd_mem_hazard_pyc(fwd_mem_hazard_pyc),
    .fwd_load_data(fwd_load_data), .fwd_retire_data(fwd_retire_data),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  logic [6:0] ctl_obs;
  logic [7:0] pyc_obs;
  assign ctl_obs = {pc_keep, ifid_keep, ifid_nop, idex_keep, idex_nop, ex_keep, ex_nop};
  assign pyc_obs = {fwd_ex_pyc, fwd_stall_load_pyc, fwd_mem_pyc, fwd_mem_hazard_pyc};

  typedef struct {
    string       tag;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];
  int   n_pass = 0;
  int   n_fail = 0;
  int   n_total = 0;

  logic [31:0]      exp_ld = '0;
  logic [31:0]      exp_rd = '0;
  logic [CNT_W-1:0] exp_stall = '0;
  logic [CNT_W-1:0] exp_flush = '0;

  function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag   = tag;
    e.value = v;
    sb.push_back(e);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    exp_t e;
    n_total++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.value) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.value);
      end
    end
  endtask

  task automatic push_all(input string name, input logic [6:0] ctl, input logic [7:0] pyc);
    push({name, ".ctl"},   32'(ctl));
    push({name, ".pyc"},   32'(pyc));
    push({name, ".ldat"},  exp_ld);
    push({name, ".rdat"},  exp_rd);
    push({name, ".stall"}, 32'(exp_stall));
    push({name, ".flush"}, 32'(exp_flush));
  endtask

  task automatic check_all(input string name);
    check({name, ".ctl"},   32'(ctl_obs));
    check({name, ".pyc"},   32'(pyc_obs));
    check({name, ".ldat"},  fwd_load_data);
    check({name, ".rdat"},  fwd_retire_data);
    check({name, ".stall"}, 32'(stall_cnt));
    check({name, ".flush"}, 32'(flush_cnt));
  endtask

  // Inputs are already driven at posedge+1; compare at negedge, then model the next edge.
  task automatic step(input string name, input logic [6:0] ctl, input logic [7:0] pyc);
    push_all(name, ctl, pyc);
    @(negedge clk);
    check_all(name);
    @(posedge clk);
    if (!mem_busy) exp_rd = memwb_data;
    if (mem_busy || ctl == CTL_LU) exp_stall = bump(exp_stall);
    if (!mem_busy && branch_taken) exp_flush = bump(exp_flush);
    if (!mem_busy && ctl == CTL_LU) exp_ld = load_rdata;
    #1;
  endtask

  task automatic ops(input logic u1, input logic [4:0] r1, input logic u2, input logic [4:0] r2);
    ex_use_rs1 = u1; ex_rs1 = r1; ex_use_rs2 = u2; ex_rs2 = r2;
  endtask

  task automatic exm(input logic rw, input logic ld, input logic [4:0] wr);
    exmem_regwrite = rw; exmem_is_load = ld; exmem_wreg = wr;
  endtask

  task automatic mwb(input logic rw, input logic [4:0] wr, input logic [31:0] d);
    memwb_regwrite = rw; memwb_wreg = wr; memwb_data = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    ops(1'b1, 5'd4, 1'b1, 5'd4);
    exm(1'b1, 1'b1, 5'd4);
    mwb(1'b1, 5'd4, 32'h1234);
    load_rdata = 32'h0; mem_busy = 1'b1; branch_taken = 1'b0;

    // Reset with a freeze and load hazard present: every output must still read 0.
    push_all("reset", CTL_NONE, 8'h00);
    @(negedge clk);
    check_all("reset");
    rst = 1'b1;
    ops(1'b0, 5'd0, 1'b0, 5'd0); exm(1'b0, 1'b0, 5'd0); mwb(1'b0, 5'd0, 32'h0);
    mem_busy = 1'b0;
    @(posedge clk); #1;

    ops(1'b1, 5'd3, 1'b1, 5'd4); exm(1'b1, 1'b0, 5'd5); mwb(1'b1, 5'd6, 32'h11);
    step("no_hazard", CTL_NONE, 8'h00);

    ops(1'b1, 5'd3, 1'b1, 5'd3); exm(1'b1, 1'b0, 5'd3); mwb(1'b1, 5'd3, 32'h22);
    step("alu_b2b", CTL_NONE, 8'hC0);

    ops(1'b0, 5'd1, 1'b1, 5'd7); exm(1'b1, 1'b1, 5'd7); mwb(1'b0, 5'd0, 32'h0);
    load_rdata = 32'hDEADBEEF;
    step("lu_stall", CTL_LU, 8'h00);

    exm(1'b0, 1'b0, 5'd0); mwb(1'b1, 5'd7, 32'h33); load_rdata = 32'h0;
    step("lu_fwd", CTL_NONE, 8'h10);

    mwb(1'b0, 5'd7, 32'h44);
    step("lu_done_retire", CTL_NONE, 8'h01);

    // Load-use hit while memory is busy for three cycles, then the deferred capture.
    ops(1'b1, 5'd8, 1'b0, 5'd0); exm(1'b1, 1'b1, 5'd8); mwb(1'b0, 5'd0, 32'h99);
    load_rdata = 32'h0BAD0BAD; mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) step("busy_lu", CTL_FRZ, 8'h00);
    mem_busy = 1'b0; load_rdata = 32'hCAFEF00D; memwb_data = 32'h45;
    step("busy_capture", CTL_LU, 8'h00);

    exm(1'b0, 1'b0, 5'd0); mwb(1'b0, 5'd0, 32'h46); load_rdata = 32'h0; branch_taken = 1'b1;
    step("flush_in_fwd", CTL_FLUSH, 8'h20);
    branch_taken = 1'b0; memwb_data = 32'h47;
    step("after_flush", CTL_NONE, 8'h00);

    ops(1'b1, 5'd0, 1'b1, 5'd0); exm(1'b1, 1'b0, 5'd0); mwb(1'b1, 5'd0, 32'h50);
    step("x0", CTL_NONE, 8'h00);
    ops(1'b1, 5'd2, 1'b0, 5'd0); exm(1'b0, 1'b0, 5'd0); mwb(1'b1, 5'd9, 32'h55);
    step("retire_src", CTL_NONE, 8'h00);
    ops(1'b1, 5'd9, 1'b0, 5'd0); mwb(1'b0, 5'd0, 32'h60);
    step("retire_fwd", CTL_NONE, 8'h02);
    exm(1'b1, 1'b0, 5'd9); mwb(1'b1, 5'd9, 32'h66);
    step("ex_over_mem", CTL_NONE, 8'h80);
    exm(1'b0, 1'b0, 5'd0); mwb(1'b1, 5'd9, 32'h67);
    step("mem_over_hz", CTL_NONE, 8'h08);

    // Freeze outranks a branch and must hold the retire capture; stall_cnt saturates at 7.
    mwb(1'b1, 5'd9, 32'h77); mem_busy = 1'b1; branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) step("freeze", CTL_FRZ, 8'h08);
    mem_busy = 1'b0; branch_taken = 1'b0; mwb(1'b0, 5'd0, 32'h78);
    step("after_freeze", CTL_NONE, 8'h02);

    ops(1'b1, 5'd10, 1'b0, 5'd0); exm(1'b1, 1'b1, 5'd10); mwb(1'b0, 5'd0, 32'h80);
    mem_busy = 1'b1;
    step("busy_lu2", CTL_FRZ, 8'h00);

    // Reset while parked in LU_STALL, then confirm no deferred capture survives.
    rst = 1'b0;
    exp_ld = '0; exp_rd = '0; exp_stall = '0; exp_flush = '0;
    push_all("mid_reset", CTL_NONE, 8'h00);
    @(negedge clk);
    check_all("mid_reset");
    exm(1'b0, 1'b0, 5'd0); mwb(1'b0, 5'd0, 32'h88); mem_busy = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    exp_rd = memwb_data;
    #1;
    step("post_reset", CTL_NONE, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
- Pipeline hazard and forwarding controller for the 5-stage core (IF, ID, EX, MEM, WB).
- Generates keep/nop controls for the PC, IF/ID, ID/EX and EX/MEM (execute) registers.
- Generates the four 2-bit forwarding selects consumed by execute.
- Sequences load-use stalls with a captured load-data bypass, handles branch/trap flushes and data-memory wait freezes, and keeps stall/flush event counters.

Parameters:
CNT_W, 32, width of stall_cnt and flush_cnt (saturating)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
ex_rs1  in  5  rs1 of instruction held in ID/EX (currently in EX)
ex_rs2  in  5  rs2 of instruction held in ID/EX
ex_use_rs1  in  1  EX instruction reads rs1 from a register
ex_use_rs2  in  1  EX instruction reads rs2 from a register
exmem_wreg  in  5  destination register in EX/MEM
exmem_regwrite  in  1  EX/MEM instruction writes a register
exmem_is_load  in  1  EX/MEM instruction is a load
memwb_wreg  in  5  destination register in MEM/WB
memwb_regwrite  in  1  MEM/WB instruction writes a register
memwb_data  in  32  MEM/WB writeback value
load_rdata  in  32  data-memory read data; valid when mem_busy=0
mem_busy  in  1  data memory not ready
branch_taken  in  1  execute branch/ecall/mret redirect
pc_keep  out  1  hold PC
ifid_keep  out  1  hold IF/ID
ifid_nop  out  1  bubble IF/ID
idex_keep  out  1  hold ID/EX
idex_nop  out  1  bubble ID/EX
ex_keep  out  1  execute keep
ex_nop  out  1  execute nop
fwd_ex_pyc  out  2  [1]=rs1, [0]=rs2 take EX/MEM ALU result
fwd_mem_pyc  out  2  take memwb_data
fwd_stall_load_pyc  out  2  take fwd_load_data
fwd_mem_hazard_pyc  out  2  take fwd_retire_data
fwd_load_data  out  32  captured load result
fwd_retire_data  out  32  last retired writeback value
stall_cnt  out  CNT_W  cycles with load-use stall or freeze
flush_cnt  out  CNT_W  flush events

Behaviour:
- FSM states: RUN, LU_STALL, LU_FWD. Reset state is RUN.
- All outputs reset to 0, and all capture registers and their valid bits clear.
- Registered outputs: fwd_load_data, fwd_retire_data and the counters. All keep/nop/pyc outputs are combinational from the inputs and the state.
- match_x(r) = use_x & (r != 0) & (ex_rsx == r).
- load_use = exmem_regwrite & exmem_is_load & (match_1(exmem_wreg) | match_2(exmem_wreg)).
- Priority, highest first:
  1. Freeze (mem_busy=1): all keep outputs =1, all nop =0. FSM state and all captures hold. stall_cnt increments.
  2. Flush (branch_taken=1, mem_busy=0): ifid_nop = idex_nop = ex_nop = 1, all keeps 0. Next state RUN. A pending LU_STALL/LU_FWD is abandoned and the L valid bit clears. flush_cnt increments.
  3. Load-use (RUN & load_use): pc_keep = ifid_keep = idex_keep = 1, ex_nop = 1. At the edge: L <= load_rdata, Lreg <= exmem_wreg, L valid set. RUN -> LU_STALL -> LU_FWD transitions happen within one cycle, i.e. the captured state is LU_FWD. stall_cnt increments.
  4. Otherwise: all keep/nop = 0.
- Capture rule: LU_STALL is entered only when mem_busy rises during the load-use cycle. In that case the capture is deferred to the first mem_busy=0 cycle, then the FSM goes to LU_FWD.
- LU_FWD lasts exactly one cycle; the consumer executes in it. Then RUN, and L valid clears.
- Forwarding per operand bit x, one-hot; the first match wins:
  1. fwd_ex: exmem_regwrite & !exmem_is_load & match_x(exmem_wreg).
  2. fwd_stall_load: state LU_FWD & L valid & match_x(Lreg).
  3. fwd_mem: memwb_regwrite & match_x(memwb_wreg).
  4. fwd_mem_hazard: retire valid & match_x(retire_reg).
- A lower-priority bit is forced to 0 when any higher one is set.
- Retire register: on every non-frozen edge, retire_reg <= memwb_wreg, fwd_retire_data <= memwb_data, retire valid <= memwb_regwrite & (memwb_wreg != 0).
- x0 never forwards.
- Counters saturate at all-ones. Freeze and load-use in the same cycle count once.
- Reset mid-stall returns the FSM to RUN with all captures invalid.

Test Plan:
- No hazard: ex_rs1=3, exmem_wreg=5, memwb_wreg=6 -> all pyc = 00, keeps/nops = 0.
- ALU back-to-back: exmem_wreg=3, regwrite, not load; ex_rs1=3, ex_rs2=3 -> fwd_ex_pyc = 11; fwd_mem_pyc = 00 even with memwb_wreg=3.
- Load-use: exmem load wreg=7, ex_rs2=7, load_rdata=0xDEADBEEF -> one cycle with pc/ifid/idex_keep=1 and ex_nop=1. Next cycle fwd_stall_load_pyc=01, fwd_load_data=0xDEADBEEF, memwb match masked. stall_cnt=1.
- Load-use with mem_busy high 3 cycles -> all keeps =1 for 3 cycles and state LU_STALL. Capture happens on the first ready cycle, then one LU_FWD cycle. stall_cnt=4.
- branch_taken during LU_FWD -> ifid/idex/ex_nop=1, state RUN, fwd_stall_load_pyc=00 next cycle, flush_cnt=1.
- x0 and retire: memwb_wreg=0 with regwrite -> no forward. memwb_wreg=9, data 0x55 retires, then ex_rs1=9 -> fwd_mem_hazard_pyc=10, fwd_retire_data=0x55. rst low mid-stall -> all outputs 0.
